// File: rtl/seg_scan_mux.sv
// Time-multiplexed hex display scanner: walks DIGITS anodes with a dead-time gap per slot,
// double-buffers the value so a frame never shows a mix of old and new digits.
module seg_scan_mux #(
  parameter int DIGITS = 4,
  parameter int DIV    = 100000,
  parameter int GAP    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  lz_blank,
  input  logic [DIGITS-1:0]     dp_en,
  output logic [3:0]            digit_out,
  output logic [DIGITS-1:0]     an_n,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  typedef enum logic {S_GAP, S_ON} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DIGITS-1:0][3:0]  shadow_q, shadow_d;
  logic [DIGITS-1:0][3:0]  disp_q, disp_d;
  logic                    lz_q;
  logic [DIGITS-1:0]       dpen_q;
  logic                    fd_q;

  logic                    slot_end, frame_end;
  logic [DIGITS-1:0]       blank;
  logic                    zacc;
  logic                    lit;

  assign slot_end  = (cnt_q == CW'(DIV - 1));
  assign frame_end = slot_end && (idx_q == IW'(DIGITS - 1));

  always_comb begin
    cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    if (slot_end) idx_d = frame_end ? '0 : idx_q + IW'(1);
    shadow_d = load ? value : shadow_q;
    // display only swaps at the frame boundary; shadow_q here is the pre-edge value
    disp_d   = frame_end ? shadow_q : disp_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_GAP:   if (cnt_q == CW'(GAP - 1)) state_d = S_ON;
      S_ON:    if (slot_end)              state_d = S_GAP;
      default: state_d = S_GAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_GAP;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      lz_q     <= 1'b0;
      dpen_q   <= '0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      lz_q     <= lz_blank;
      dpen_q   <= dp_en;
      fd_q     <= frame_end;
    end
  end

  // digit k blanks when every nibble from k upward is zero; digit 0 always shows
  always_comb begin
    blank = '0;
    zacc  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zacc     = zacc & (disp_q[k] == 4'h0);
      blank[k] = lz_q & zacc;
    end
  end

  assign lit        = (state_q == S_ON) && !blank[idx_q];
  assign an_n       = lit ? ~(DIGITS'(1) << idx_q) : '1;
  assign dp_n       = lit ? ~dpen_q[idx_q] : 1'b1;
  assign digit_out  = disp_q[idx_q];
  assign frame_done = fd_q;

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter DIGITS, default 4, sets the number of multiplexed digits (legal range 2..8).
REQ-002 Parameter DIV, default 100000, sets the clock cycles per digit slot.
REQ-003 Parameter GAP, default 16, sets the all-anodes-off cycles at the start of each slot; legal range 1 <= GAP < DIV.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 value  in  4*DIGITS  hex digits to display; nibble k is digit k, and digit 0 is least significant.
REQ-007 load  in  1  when 1, value is captured into the shadow register.
REQ-008 lz_blank  in  1  enables leading-zero blanking.
REQ-009 dp_en  in  DIGITS  per-digit decimal-point enable, active high.
REQ-010 digit_out  out  4  nibble of the current digit; feeds the downstream 7-segment decoder seg_in.
REQ-011 an_n  out  DIGITS  active-low anode enables.
REQ-012 dp_n  out  1  active-low decimal point.
REQ-013 frame_done  out  1  one-cycle pulse at the end of each full scan.

Function
REQ-014 Slot counter cnt SHALL count 0..DIV-1 and wrap to 0; at the wrap, digit index idx SHALL advance by 1, with DIGITS-1 wrapping to 0.
REQ-015 Two-state slot FSM SHALL apply:
- GAP while cnt < GAP.
- ON while GAP <= cnt <= DIV-1.
- GAP->ON at cnt == GAP; ON->GAP at the slot wrap.
REQ-016 In GAP, an_n SHALL be all ones and dp_n SHALL be 1 (anti-ghosting dead time).
REQ-017 In ON, an_n SHALL be all ones except bit idx = 0, unless digit idx is blanked, in which case an_n is all ones.
REQ-018 In ON, dp_n SHALL equal ~dp_en[idx]; when digit idx is blanked, dp_n SHALL be 1.
REQ-019 digit_out SHALL equal display-register nibble idx in both states.
REQ-020 Outputs SHALL be decoded from registered state only; there SHALL be no combinational path from any input to any output.
REQ-021 Blanking rule: digit k (k >= 1) is blanked iff lz_blank = 1 and display nibbles k..DIGITS-1 are all zero; digit 0 is never blanked.
REQ-022 Buffering:
- load = 1 writes value into the shadow register on that edge.
- The display register is loaded from the shadow only on the edge where cnt wraps and idx wraps DIGITS-1 -> 0 (frame boundary).
- The displayed value therefore never changes mid-frame (no tearing).
REQ-023 If load and the frame boundary occur on the same edge, the display register SHALL take the old shadow contents, and the new value SHALL appear one frame later.
REQ-024 frame_done SHALL be 1 for exactly the cycle following the frame-boundary edge, i.e. once every DIGITS*DIV cycles.
REQ-025 lz_blank and dp_en SHALL be sampled live each cycle (not buffered).

Reset
REQ-026 While rst_n = 0 at a rising edge, the next state SHALL be: cnt = 0, idx = 0, shadow = 0, display = 0, FSM = GAP.
REQ-027 Output values under reset SHALL be: an_n = all ones, dp_n = 1, digit_out = 0, frame_done = 0.
REQ-028 Reset asserted mid-slot or mid-frame SHALL abort the scan, with no partial digit lit on the following cycle.
REQ-029 After rst_n returns to 1, scanning SHALL restart from digit 0 in GAP; the first frame_done SHALL occur DIGITS*DIV cycles later.

Verification (DIGITS=4, DIV=8, GAP=2)
REQ-030 Reset: rst_n = 0 for 3 cycles -> an_n = 4'b1111, digit_out = 0, dp_n = 1, frame_done = 0 throughout.
REQ-031 Scan: load value = 16'h1234, lz_blank = 0.
- From the next frame, slot 0: cycles 0-1 an_n = 1111, cycles 2-7 an_n = 1110 with digit_out = 4.
- Slots 1/2/3 show an_n = 1101/1011/0111 with digit_out = 3/2/1.
- frame_done pulses every 32 cycles.
REQ-032 Blanking: value = 16'h0050, lz_blank = 1.
- Digits 3 and 2: an_n stays 1111 for the whole slot.
- Digits 1 and 0: show 5 and 0.
- value = 0 -> only digit 0 lit; lz_blank = 0 -> all four digits lit.
REQ-033 Tear-free update: load 16'hABCD during slot 2 -> digits keep the old value until frame_done; the next frame shows D, C, B, A.
REQ-034 Simultaneous: load = 1 on the frame-boundary edge -> the following frame shows the previous shadow, and the frame after shows the new value.
REQ-035 Mid-scan reset and decimal point:
- rst_n = 0 at cnt = 5, idx = 2 -> next cycle an_n = 1111, digit_out = 0; the scan restarts at digit 0.
- dp_en = 4'b0100 -> dp_n = 0 only during ON of slot 2.
